matrix_mult_seq: RTL and testbench
==================================

Name: matrix_mult_seq

Overview:
- Sequencing controller wrapped around the pipelined `matrix_mult` datapath (N×N operands, PIPE_STAGES-deep pipeline).
- Accepts operands as a row stream over a valid/ready handshake, A rows first, then B rows. Holds both matrices stable on the datapath inputs.
- Waits out the pipeline latency, captures C into a result buffer, then streams C back out row by row over a second valid/ready handshake.
- Sole owner of the multiplier's A/B inputs. No overlap: one job in flight.

Parameters:
- N, 4, matrix dimension (≥2, power of two).
- WIDTH, 16, operand element width in bits.
- PIPE_STAGES, 5, register latency of `matrix_mult` from stable A/B to valid C (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- soft_clr  in  1  synchronous abort; returns to LOAD.
- in_valid  in  1  operand row valid.
- in_ready  out  1  operand row accepted when in_valid&&in_ready.
- in_data  in  N*WIDTH  one operand row; element j at bits [j*WIDTH +: WIDTH].
- mm_a  out  N*N*WIDTH  flattened A to datapath; element [i][j] at (i*N+j)*WIDTH.
- mm_b  out  N*N*WIDTH  flattened B to datapath, same packing.
- mm_c  in  N*N*2*WIDTH  flattened C from datapath; element [i][j] at (i*N+j)*2*WIDTH.
- out_valid  out  1  result row valid.
- out_ready  in  1  sink accepts row.
- out_data  out  N*2*WIDTH  result row; element j at bits [j*2*WIDTH +: 2*WIDTH].
- out_row  out  $clog2(N)  index of the row on out_data.
- out_last  out  1  high with row N-1.
- busy  out  1  high in WAIT or DRAIN.
- done  out  1  one-cycle pulse after the last result row is accepted.

Behaviour:
- **States:** LOAD, WAIT, DRAIN. Single registered state, beat counter beat_cnt (0..2N-1), wait counter wait_cnt (0..PIPE_STAGES), row counter row_cnt (0..N-1).
- **Reset (rst_n low, asynchronous):**
  - state=LOAD; all counters 0; operand registers 0; result buffer 0.
  - out_valid=0, done=0, busy=0, out_row=0, out_last=0.
  - in_ready=1 once rst_n deasserts.
- **LOAD:**
  - in_ready=1 (combinational from state); out_valid=0.
  - Each handshake writes in_data to A row beat_cnt (beat_cnt<N) or to B row beat_cnt-N, then increments beat_cnt.
  - Handshake at beat_cnt=2N-1 clears beat_cnt, clears wait_cnt, goes to WAIT.
  - Idle cycles (in_valid=0) change nothing.
- **WAIT:**
  - in_ready=0. wait_cnt increments each cycle.
  - On the edge where wait_cnt=PIPE_STAGES: capture mm_c into the result buffer, clear row_cnt, go to DRAIN.
  - Net timing: last input handshake at edge k, capture at edge k+PIPE_STAGES+1, out_valid high from edge k+PIPE_STAGES+1.
- **DRAIN:**
  - out_valid=1; out_data = buffer row row_cnt; out_row=row_cnt; out_last=(row_cnt==N-1).
  - On handshake, row_cnt increments.
  - Handshake with out_last goes to LOAD and pulses done for exactly one cycle.
  - out_ready low holds out_data and out_row stable; no row is skipped or repeated.
- **Operand hold:** mm_a and mm_b are driven directly from the operand registers. They change only on LOAD handshakes and stay constant through WAIT and DRAIN.
- **Arithmetic:** none in this block. C width is 2*WIDTH per element, copied bit-exact from mm_c.
- **soft_clr:**
  - Highest priority over all other events in the same cycle.
  - Next state LOAD; all counters 0; out_valid=0; done=0.
  - Operand and result registers are not cleared.
  - A handshake coinciding with soft_clr is discarded.
- **Reset mid-operation:** asynchronous return to the reset values above in any state; no done pulse.
- **Counter wrap:** counters never exceed their terminal values. beat_cnt, wait_cnt and row_cnt roll to 0 only via the transitions above.

Test Plan:
- **Identity multiply:** load A[i][j]=i+j, B=I as 8 back-to-back beats.
  - in_ready falls after beat 8.
  - out_valid rises 6 edges after the beat-8 edge.
  - Rows are {0,1,2,3}, {1,2,3,4}, {2,3,4,5}, {3,4,5,6}; out_last on row 3; done pulses once.
- **Gapped input:** toggle in_valid every other cycle.
  - Same C as the identity case.
  - beat_cnt does not advance on idle cycles.
  - mm_a/mm_b unchanged from LOAD exit to done.
- **Output backpressure:** out_ready low for 3 cycles on row 1.
  - out_row=1 and its data held stable.
  - Rows arrive in order 0..3 with no duplicates.
- **Max values:** A=B=all 0xFFFF.
  - Every C element equals 4*0xFFFE0001 mod 2^32 = 0xFFF80004, passed unmodified.
- **soft_clr:**
  - Assert during WAIT (wait_cnt=2) → next cycle state LOAD, in_ready=1, no out_valid, no done. A full reload then produces correct results.
  - Repeat with soft_clr in DRAIN at row 2 → out_valid drops next cycle.
- **Async reset:** drop rst_n mid-DRAIN between clock edges.
  - out_valid, done and busy go 0 immediately.
  - in_ready=1 after release.

Source files
------------

// File: rtl/matrix_mult_seq.sv
// Sequencing controller for the pipelined matrix_mult datapath.
// Collects A then B as a row stream, holds them on the datapath inputs,
// waits out the pipeline latency, buffers C and streams it back row by row.
module matrix_mult_seq #(
    parameter int unsigned N           = 4,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned PIPE_STAGES = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       soft_clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*WIDTH-1:0]         in_data,
    output logic [N*N*WIDTH-1:0]       mm_a,
    output logic [N*N*WIDTH-1:0]       mm_b,
    input  logic [N*N*2*WIDTH-1:0]     mm_c,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*2*WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]       out_row,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned RW   = $clog2(N);
    localparam int unsigned BW   = RW + 1;
    localparam int unsigned WW   = $clog2(PIPE_STAGES + 1);
    localparam int unsigned AROW = N * WIDTH;
    localparam int unsigned CROW = N * 2 * WIDTH;

    typedef enum logic [1:0] {
        StLoad,
        StWait,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [RW-1:0]     row_cnt_q, row_cnt_d;
    logic              done_q, done_d;

    logic [AROW-1:0]   a_q [N];
    logic [AROW-1:0]   b_q [N];
    logic [CROW-1:0]   c_q [N];

    logic              a_we, b_we, c_we;
    logic              in_hs, out_hs;
    logic [RW-1:0]     beat_row;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    // N is a power of two, so the low bits index the row and the top bit picks A or B.
    assign beat_row = beat_cnt_q[RW-1:0];

    // Next-state and counter control; soft_clr overrides every other event.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        row_cnt_d  = row_cnt_q;
        done_d     = 1'b0;
        a_we       = 1'b0;
        b_we       = 1'b0;
        c_we       = 1'b0;
        if (soft_clr) begin
            state_d    = StLoad;
            beat_cnt_d = '0;
            wait_cnt_d = '0;
            row_cnt_d  = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (in_hs) begin
                        if (beat_cnt_q[BW-1]) begin
                            b_we = 1'b1;
                        end else begin
                            a_we = 1'b1;
                        end
                        if (beat_cnt_q == BW'(2 * N - 1)) begin
                            beat_cnt_d = '0;
                            wait_cnt_d = '0;
                            state_d    = StWait;
                        end else begin
                            beat_cnt_d = beat_cnt_q + BW'(1);
                        end
                    end
                end
                StWait: begin
                    if (wait_cnt_q == WW'(PIPE_STAGES)) begin
                        c_we       = 1'b1;
                        wait_cnt_d = '0;
                        row_cnt_d  = '0;
                        state_d    = StDrain;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
                StDrain: begin
                    if (out_hs) begin
                        if (row_cnt_q == RW'(N - 1)) begin
                            row_cnt_d = '0;
                            done_d    = 1'b1;
                            state_d   = StLoad;
                        end else begin
                            row_cnt_d = row_cnt_q + RW'(1);
                        end
                    end
                end
                default: state_d = StLoad;
            endcase
        end
    end

    // State, counters and the done pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            beat_cnt_q <= '0;
            wait_cnt_q <= '0;
            row_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            row_cnt_q  <= row_cnt_d;
            done_q     <= done_d;
        end
    end

    // Operand registers; written only on LOAD handshakes, so they stay stable for the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            if (a_we) a_q[beat_row] <= in_data;
            if (b_we) b_q[beat_row] <= in_data;
        end
    end

    // Result buffer; captures the whole C matrix once the pipeline has settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) c_q[i] <= '0;
        end else if (c_we) begin
            for (int i = 0; i < N; i++) c_q[i] <= mm_c[i*CROW +: CROW];
        end
    end

    // Flatten operand rows onto the datapath buses.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        for (int i = 0; i < N; i++) begin
            mm_a[i*AROW +: AROW] = a_q[i];
            mm_b[i*AROW +: AROW] = b_q[i];
        end
    end

    // Handshake and status outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state_q == StLoad);
        out_valid = (state_q == StDrain);
        busy      = (state_q != StLoad);
        out_row   = row_cnt_q;
        out_last  = (state_q == StDrain) && (row_cnt_q == RW'(N - 1));
        out_data  = c_q[row_cnt_q];
        done      = done_q;
    end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Directed bench for matrix_mult_seq with a behavioural pipelined multiplier on mm_c.
module tb_matrix_mult_seq;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned PS = 5;

    logic                   clk;
    logic                   rst_n;
    logic                   soft_clr;
    logic                   in_valid;
    logic                   in_ready;
    logic [N*W-1:0]         in_data;
    logic [N*N*W-1:0]       mm_a;
    logic [N*N*W-1:0]       mm_b;
    logic [N*N*2*W-1:0]     mm_c;
    logic                   out_valid;
    logic                   out_ready;
    logic [N*2*W-1:0]       out_data;
    logic [$clog2(N)-1:0]   out_row;
    logic                   out_last;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int errors = 0;

    matrix_mult_seq #(.N(N), .WIDTH(W), .PIPE_STAGES(PS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .soft_clr  (soft_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_c      (mm_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: product of mm_a and mm_b delayed by PS registers.
    function automatic logic [N*N*2*W-1:0] matmul(input logic [N*N*W-1:0] a,
                                                   input logic [N*N*W-1:0] b);
        logic [N*N*2*W-1:0] c;
        logic [31:0] acc;
        logic [15:0] ae, be;
        c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int k = 0; k < N; k++) begin
                    ae  = a[(i*N+k)*W +: W];
                    be  = b[(k*N+j)*W +: W];
                    acc = acc + 32'(ae) * 32'(be);
                end
                c[(i*N+j)*2*W +: 2*W] = acc;
            end
        end
        return c;
    endfunction

    logic [N*N*2*W-1:0] pipe [PS];
    always @(posedge clk) begin
        pipe[0] <= matmul(mm_a, mm_b);
        for (int s = 1; s < PS; s++) pipe[s] <= pipe[s-1];
    end
    assign mm_c = pipe[PS-1];

    function automatic logic [63:0] arow(input logic [15:0] e0, input logic [15:0] e1,
                                         input logic [15:0] e2, input logic [15:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [127:0] crow(input logic [31:0] e0, input logic [31:0] e1,
                                          input logic [31:0] e2, input logic [31:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Eight beats: A rows then B rows; with gap, one idle cycle with junk data between beats.
    task automatic load_job(input logic [255:0] a, input logic [255:0] b, input bit gap);
        for (int r = 0; r < 2 * N; r++) begin
            in_data  = (r < N) ? a[r*64 +: 64] : b[(r-N)*64 +: 64];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (gap && r != 2 * N - 1) begin
                in_data = {$urandom, $urandom};
                step();
            end
        end
    endtask

    // Called right after the last beat edge: out_valid must rise exactly PS+1 edges later.
    task automatic wait_result(input string tag);
        check({tag, "_in_ready_low"}, 256'(in_ready), 256'(0));
        check({tag, "_busy"}, 256'(busy), 256'(1));
        for (int i = 0; i < PS; i++) begin
            step();
            check({tag, "_early_valid"}, 256'(out_valid), 256'(0));
        end
        step();
        check({tag, "_valid_rise"}, 256'(out_valid), 256'(1));
    endtask

    task automatic drain_row(input string tag, input int r, input logic [127:0] exp);
        check({tag, "_out_valid"}, 256'(out_valid), 256'(1));
        check({tag, "_out_row"}, 256'(out_row), 256'(r));
        check({tag, "_out_data"}, 256'(out_data), 256'(exp));
        check({tag, "_out_last"}, 256'(out_last), 256'(r == N - 1));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        check({tag, "_done_pulse"}, 256'(done), 256'(1));
        check({tag, "_valid_drop"}, 256'(out_valid), 256'(0));
        check({tag, "_in_ready_back"}, 256'(in_ready), 256'(1));
        step();
        check({tag, "_done_single"}, 256'(done), 256'(0));
    endtask

    logic [255:0] a_ipj, b_id, b_ones, a_seq, b_two, m_max;
    logic [127:0] c_ipj [N];
    logic [127:0] c_seq [N];
    logic [127:0] c_ones [N];
    logic [127:0] c_id [N];

    initial begin
        a_ipj  = {arow(3, 4, 5, 6), arow(2, 3, 4, 5), arow(1, 2, 3, 4), arow(0, 1, 2, 3)};
        b_id   = {arow(0, 0, 0, 1), arow(0, 0, 1, 0), arow(0, 1, 0, 0), arow(1, 0, 0, 0)};
        b_ones = {4{arow(1, 1, 1, 1)}};
        a_seq  = {arow(12, 13, 14, 15), arow(8, 9, 10, 11), arow(4, 5, 6, 7), arow(0, 1, 2, 3)};
        b_two  = {arow(0, 0, 0, 2), arow(0, 0, 2, 0), arow(0, 2, 0, 0), arow(2, 0, 0, 0)};
        m_max  = {16{16'hFFFF}};
        c_ipj[0] = crow(0, 1, 2, 3);
        c_ipj[1] = crow(1, 2, 3, 4);
        c_ipj[2] = crow(2, 3, 4, 5);
        c_ipj[3] = crow(3, 4, 5, 6);
        c_seq[0] = crow(0, 2, 4, 6);
        c_seq[1] = crow(8, 10, 12, 14);
        c_seq[2] = crow(16, 18, 20, 22);
        c_seq[3] = crow(24, 26, 28, 30);
        c_ones[0] = crow(6, 6, 6, 6);
        c_ones[1] = crow(10, 10, 10, 10);
        c_ones[2] = crow(14, 14, 14, 14);
        c_ones[3] = crow(18, 18, 18, 18);
        c_id[0] = crow(1, 0, 0, 0);
        c_id[1] = crow(0, 1, 0, 0);
        c_id[2] = crow(0, 0, 1, 0);
        c_id[3] = crow(0, 0, 0, 1);

        rst_n     = 1'b0;
        soft_clr  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_out_row", 256'(out_row), 256'(0));
        check("rst_out_last", 256'(out_last), 256'(0));
        check("rst_mm_a", 256'(mm_a), 256'(0));
        check("rst_mm_b", 256'(mm_b), 256'(0));

        // Identity multiply, back-to-back beats
        load_job(a_ipj, b_id, 1'b0);
        wait_result("id");
        for (int r = 0; r < N; r++) drain_row("id", r, c_ipj[r]);
        finish_job("id");

        // Gapped input; operands must stay put from LOAD exit to done
        load_job(a_ipj, b_id, 1'b1);
        check("gap_mm_a_exit", 256'(mm_a), a_ipj);
        check("gap_mm_b_exit", 256'(mm_b), b_id);
        wait_result("gap");
        for (int r = 0; r < N; r++) drain_row("gap", r, c_ipj[r]);
        check("gap_mm_a_done", 256'(mm_a), a_ipj);
        check("gap_mm_b_done", 256'(mm_b), b_id);
        finish_job("gap");

        // Output backpressure on row 1
        load_job(a_seq, b_two, 1'b0);
        wait_result("bp");
        drain_row("bp", 0, c_seq[0]);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_row", 256'(out_row), 256'(1));
            check("bp_hold_data", 256'(out_data), 256'(c_seq[1]));
            check("bp_hold_valid", 256'(out_valid), 256'(1));
        end
        for (int r = 1; r < N; r++) drain_row("bp", r, c_seq[r]);
        finish_job("bp");

        // Max values
        load_job(m_max, m_max, 1'b0);
        wait_result("max");
        for (int r = 0; r < N; r++) drain_row("max", r, {4{32'hFFF80004}});
        finish_job("max");

        // soft_clr during WAIT at wait_cnt=2, then a full reload
        load_job(a_seq, b_id, 1'b0);
        step();
        step();
        soft_clr = 1'b1;
        step();
        soft_clr = 1'b0;
        check("sc_wait_in_ready", 256'(in_ready), 256'(1));
        check("sc_wait_busy", 256'(busy), 256'(0));
        for (int i = 0; i < PS + 3; i++) begin
            check("sc_wait_no_valid", 256'(out_valid), 256'(0));
            check("sc_wait_no_done", 256'(done), 256'(0));
            step();
        end
        load_job(a_ipj, b_ones, 1'b0);
        wait_result("sc_reload");
        for (int r = 0; r < N; r++) drain_row("sc_reload", r, c_ones[r]);
        finish_job("sc_reload");

        // soft_clr in DRAIN at row 2
        load_job(a_seq, b_two, 1'b0);
        wait_result("scd");
        drain_row("scd", 0, c_seq[0]);
        drain_row("scd", 1, c_seq[1]);
        check("scd_row2", 256'(out_row), 256'(2));
        soft_clr  = 1'b1;
        out_ready = 1'b1;
        step();
        soft_clr  = 1'b0;
        out_ready = 1'b0;
        check("scd_valid_drop", 256'(out_valid), 256'(0));
        check("scd_no_done", 256'(done), 256'(0));
        check("scd_in_ready", 256'(in_ready), 256'(1));
        step();
        check("scd_no_done_later", 256'(done), 256'(0));

        // Async reset mid-DRAIN, between clock edges
        load_job(a_ipj, b_id, 1'b0);
        wait_result("ar");
        drain_row("ar", 0, c_ipj[0]);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_now", 256'(out_valid), 256'(0));
        check("ar_done_now", 256'(done), 256'(0));
        check("ar_busy_now", 256'(busy), 256'(0));
        check("ar_last_now", 256'(out_last), 256'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        check("ar_in_ready", 256'(in_ready), 256'(1));
        check("ar_out_valid", 256'(out_valid), 256'(0));
        check("ar_done", 256'(done), 256'(0));
        check("ar_mm_a_cleared", 256'(mm_a), 256'(0));

        // Recovery job after reset
        load_job(b_id, b_id, 1'b0);
        wait_result("rec");
        for (int r = 0; r < N; r++) drain_row("rec", r, c_id[r]);
        finish_job("rec");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
